// File: rtl/midi_note_tx.sv
`timescale 1ns / 1ps
// midi_note_tx: MIDI note event transmitter.
//
// Note On / Note Off strobes are queued in a small FIFO. Each queued event is
// sent as a 3-byte MIDI channel message (status, note, velocity) on an
// 8N1 UART line at BAUD bits per second.
//
// Optional build macro:
//   MIDI_RUNNING_STATUS_EN - if defined, the status byte is skipped when it
//                            matches the last status byte sent.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   note_on  in   single-cycle strobe, enqueue Note On
//   note_off in   single-cycle strobe, enqueue Note Off (note_on wins if both)
//   note     in   [6:0] note number, sampled with a strobe
//   velocity in   [6:0] Note On velocity (Note Off always sends 0x40)
//   tx       out  serial MIDI output, idle high
//   busy     out  message in flight or FIFO non-empty
//   full     out  FIFO full
//   drop     out  one-cycle pulse after a strobe was discarded (FIFO full)
module midi_note_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 31250,
  parameter int unsigned CHANNEL  = 0,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_on,
  input  logic       note_off,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       drop
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned Depth      = 1 << FIFO_AW;
  localparam logic [CntW-1:0] BaudReload = CntW'(ClksPerBit - 1);
  localparam logic [3:0]      Chan       = 4'(CHANNEL);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO entry: {type, note, velocity}, type=1 for Note On.
  logic [14:0]        mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               empty, strobe, wr_en, pop;
  logic [14:0]        wr_entry, head;
  logic [7:0]         head_status;
  logic               skip_status;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic            msg_type_q, msg_type_d;
  logic [6:0]      msg_note_q, msg_note_d;
  logic [6:0]      msg_vel_q, msg_vel_d;
  logic            tx_q, tx_d;
  logic            drop_q;
  logic            start_msg;
  logic [7:0]      cur_byte;

  assign empty    = (count_q == '0);
  assign full     = (count_q == Depth[FIFO_AW:0]);
  assign strobe   = note_on | note_off;
  assign wr_entry = note_on ? {1'b1, note, velocity} : {1'b0, note, 7'h40};
  // A pop on the same edge frees a slot, so a write into a full FIFO is accepted.
  assign wr_en    = strobe & (~full | pop);

  assign head        = mem_q[rd_ptr_q];
  assign head_status = {(head[14] ? 4'h9 : 4'h8), Chan};

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q;
  assign skip_status = (head_status == last_status_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_status_q <= 8'h00;
    end else if (pop && !skip_status) begin
      last_status_q <= head_status;
    end
  end
`else
  assign skip_status = 1'b0;
`endif

  always_comb begin
    unique case (byte_q)
      2'd1:    cur_byte = {1'b0, msg_note_q};
      2'd2:    cur_byte = {1'b0, msg_vel_q};
      default: cur_byte = {(msg_type_q ? 4'h9 : 4'h8), Chan};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    msg_type_d = msg_type_q;
    msg_note_d = msg_note_q;
    msg_vel_d  = msg_vel_q;
    tx_d       = 1'b1;
    start_msg  = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) start_msg = 1'b1;
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_q == '0) begin
          baud_d  = BaudReload;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StData: begin
        tx_d = cur_byte[bit_q];
        if (baud_q == '0) begin
          baud_d = BaudReload;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_q == '0) begin
          if (byte_q < 2'd2) begin
            byte_d  = byte_q + 2'd1;
            baud_d  = BaudReload;
            state_d = StStart;
          end else if (!empty) begin
            // Chain straight into the next message: no idle bit between frames.
            start_msg = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_msg) begin
      pop        = 1'b1;
      msg_type_d = head[14];
      msg_note_d = head[13:7];
      msg_vel_d  = head[6:0];
      byte_d     = skip_status ? 2'd1 : 2'd0;
      bit_d      = 3'd0;
      baud_d     = BaudReload;
      state_d    = StStart;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      msg_type_q <= 1'b0;
      msg_note_q <= '0;
      msg_vel_q  <= '0;
      tx_q       <= 1'b1;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      msg_type_q <= msg_type_d;
      msg_note_q <= msg_note_d;
      msg_vel_q  <= msg_vel_d;
      // Registered line output: tx trails the state by one clock.
      tx_q       <= tx_d;
      drop_q     <= strobe & ~wr_en;
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle) | ~empty;
  assign drop = drop_q;

endmodule

// File: tb/tb_midi_note_tx.sv
`timescale 1ns / 1ps
// Testbench for midi_note_tx: a UART monitor decodes tx into bytes, and a
// message-level model (events -> MIDI byte list) supplies expected bytes.
module tb_midi_note_tx;

  localparam int unsigned CLK_FREQ = 200000;
  localparam int unsigned BAUD     = 20000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned CH       = 3;
  localparam int unsigned PERIOD   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       note_on = 1'b0;
  logic       note_off = 1'b0;
  logic [6:0] note = '0;
  logic [6:0] velocity = '0;
  logic       tx, busy, full, drop;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  time        start_q[$];
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] exp_last = 8'h00;
`endif

  midi_note_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .CHANNEL (CH),
    .FIFO_AW (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .note_on (note_on),
    .note_off(note_off),
    .note    (note),
    .velocity(velocity),
    .tx      (tx),
    .busy    (busy),
    .full    (full),
    .drop    (drop)
  );

  always #(PERIOD / 2) clk = ~clk;

  // UART monitor: sample mid-bit, record byte and its start-bit time.
  initial begin : monitor
    logic [7:0] b;
    time        t0;
    forever begin
      @(negedge tx);
      t0 = $time;
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1 b[i] = tx;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (tx) begin
          rx_q.push_back(b);
          start_q.push_back(t0);
        end
      end
    end
  end

  initial begin : watchdog
    #(2000000);
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  // Reference model: one note event -> MIDI bytes on the wire. Returns byte count.
  function automatic int model_event(input bit is_on, input logic [6:0] n,
                                     input logic [6:0] v);
    logic [7:0] st;
    int         cnt;
    st  = {(is_on ? 4'h9 : 4'h8), 4'(CH)};
    cnt = 3;
`ifdef MIDI_RUNNING_STATUS_EN
    if (st == exp_last) cnt = 2;
    else exp_q.push_back(st);
    exp_last = st;
`else
    exp_q.push_back(st);
`endif
    exp_q.push_back({1'b0, n});
    exp_q.push_back({1'b0, (is_on ? v : 7'h40)});
    return cnt;
  endfunction

  task automatic send(input bit on, input bit off, input logic [6:0] n,
                      input logic [6:0] v);
    @(negedge clk);
    note_on  = on;
    note_off = off;
    note     = n;
    velocity = v;
    @(negedge clk);
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
    @(negedge clk);
    rst = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    exp_last = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single;
    int n;
    bit ok;
    n = model_event(1'b1, 7'd60, 7'd100);
    send(1'b1, 1'b0, 7'd60, 7'd100);
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_lat1: tx=%b want 1", tx); end
    @(posedge clk); #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_lat2: tx=%b want 0", tx); end
    repeat (n * 10 * CPB - 2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b want 1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: busy stuck 1, want 0"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_note_off;
    int n;
    bit ok;
    n = model_event(1'b0, 7'd60, 7'd5);
    send(1'b0, 1'b1, 7'd60, 7'd5);
    wait_idle(ok);
    checks++; if (!ok || n != 3) begin errors++; $display("FAIL off_idle: ok=%0d n=%0d want 1,3", ok, n); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL off_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL off_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_overflow;
    int         n;
    bit         ok;
    logic [6:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 7'($urandom_range(0, 127));
      @(negedge clk);
      if (i == 5) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL ovf_nodrop: got %b want 0", drop); end
      end
      note_on  = 1'b1;
      note     = 7'(i + 1);
      velocity = v;
      if (i < 5) n = model_event(1'b1, 7'(i + 1), v);
    end
    @(posedge clk); #1;
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL ovf_drop: got %b want 1", drop); end
    @(negedge clk);
    note_on = 1'b0;
    @(posedge clk); #1;
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL ovf_drop_pulse: got %b want 0", drop); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_idle: busy stuck 1, want 0"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_simultaneous;
    int         n;
    bit         ok;
    logic [6:0] v;
    v = 7'($urandom_range(0, 127));
    n = model_event(1'b1, 7'd64, v);
    send(1'b1, 1'b1, 7'd64, v);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL simul_idle: busy stuck 1, want 0"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL simul_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL simul_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_back_to_back;
    bit         ok;
    int         nb;
    logic [6:0] v1, v2;
    v1 = 7'($urandom_range(0, 127));
    v2 = 7'($urandom_range(0, 127));
    nb = model_event(1'b1, 7'd60, v1);
    nb = model_event(1'b1, 7'd62, v2);
    send(1'b1, 1'b0, 7'd60, v1);
    send(1'b1, 1'b0, 7'd62, v2);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: busy stuck 1, want 0"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
        end
        checks++;
        if (start_q[i] - start_q[0] != time'(i * 10 * CPB * PERIOD)) begin
          errors++; $display("FAIL b2b_gap%0d: start offset %0t want %0d", i,
                             start_q[i] - start_q[0], i * 10 * CPB * PERIOD);
        end
      end
    end
    rx_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_random;
    bit         ok;
    int         nb, kind, burst;
    logic [6:0] n, v;
    for (int b = 0; b < 15; b++) begin
      burst = $urandom_range(1, 4);
      for (int e = 0; e < burst; e++) begin
        kind = $urandom_range(0, 3);
        n    = 7'($urandom_range(0, 127));
        v    = 7'($urandom_range(0, 127));
        nb   = model_event(kind != 1, n, v);
        send(kind != 1, kind == 1 || kind == 2, n, v);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_idle%0d: busy stuck 1, want 0", b); end
      checks++;
      if (rx_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_count%0d: got %0d bytes want %0d", b, rx_q.size(),
                           exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (rx_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", b, i, rx_q[i], exp_q[i]);
          end
        end
      end
      rx_q.delete(); exp_q.delete(); start_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int         n, off;
    logic [6:0] v;
    v   = 7'($urandom_range(0, 127)) & 7'h6F;  // bit 4 low so the line is 0 there
    n   = model_event(1'b1, 7'd72, v);
    // Start of the byte with index 2 (last byte sent), then middle of data bit 4.
    off = (n - 1) * 10 * CPB + 5 * CPB + CPB / 2;
    send(1'b1, 1'b0, 7'd72, v);
    repeat (off + 2) @(posedge clk);
    #3;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit4: tx=%b want 0", tx); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
    exp_last = 8'h00;
`endif
    repeat (12 * CPB) @(posedge clk);
    rx_q.delete(); start_q.delete();
    repeat (40 * CPB) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 0) begin
      errors++; $display("FAIL mid_nobytes: got %0d bytes want 0", rx_q.size());
    end
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_after: tx=%b busy=%b want 1,0", tx, busy);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_note_off;
    test_overflow;
    test_simultaneous;
    test_back_to_back;
    test_random;
    test_reset_mid;
    test_single;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
